// File: rtl/hdc_pkg.sv
// Shared constants, types and state encoding for the HDC level-HV datapath.
// The level-HV bank is filled in segments of FEATURES_PER_CC by the quantizer/IM-fetch stage.
package hdc_pkg;

    localparam int HV_DIM          = 4096;
    localparam int FEATURE_COUNT   = 617;
    localparam int FEATURES_PER_CC = 155;
    localparam int IDX_W           = 10;

    typedef logic [HV_DIM-1:0] hv_t;
    typedef logic [IDX_W-1:0]  feat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM,
        DONE
    } lvl_stream_state_e;

    localparam feat_idx_t LAST_IDX = feat_idx_t'(FEATURE_COUNT - 1);

    function automatic logic is_last_idx(input feat_idx_t idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/hv_out_reg.sv
// Single-entry valid/ready output register for one level HV plus its index/last sideband.
// The caller asserts i_load only when the entry is empty or being accepted in the same cycle.
module hv_out_reg
    import hdc_pkg::*;
(
    input  logic      clk,
    input  logic      srst,
    input  logic      i_load,
    input  logic      i_accept,
    input  hv_t       i_hv,
    input  feat_idx_t i_idx,
    input  logic      i_last,
    output logic      o_valid,
    output hv_t       o_hv,
    output feat_idx_t o_idx,
    output logic      o_last
);

    logic      r_valid;
    hv_t       r_hv;
    feat_idx_t r_idx;
    logic      r_last;

    // Payload only changes on a load, so it holds steady for the whole stall.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_hv    <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_hv    <= i_hv;
            r_idx   <= i_idx;
            r_last  <= i_last;
        end else if (i_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_hv    = r_hv;
    assign o_idx   = r_idx;
    assign o_last  = r_last;

endmodule

// File: rtl/level_hv_streamer.sv
// Streams the completed level-HV bank one feature per beat to the encoder (valid/ready).
// Optional macro LVL_STREAM_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module level_hv_streamer
    import hdc_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        bank_full,
    input  hv_t         level_hvs [FEATURE_COUNT],
    output logic        out_valid,
    input  logic        out_ready,
    output hv_t         out_hv,
    output feat_idx_t   out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
`ifdef LVL_STREAM_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    lvl_stream_state_e r_state;
    lvl_stream_state_e w_state_next;
    feat_idx_t         r_rd_ptr;
    feat_idx_t         w_rd_ptr_next;
    logic              r_more;
    logic              w_more_next;
    logic              w_load;
    logic              w_accept;
    logic              w_enter_stream;
    hv_t               w_rd_hv;

    assign w_accept = out_valid && out_ready;
    assign w_rd_hv  = level_hvs[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_more   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_more   <= w_more_next;
        end
    end

    // r_more marks that level_hvs[r_rd_ptr] has not been handed to the output register yet;
    // it drops once the last index is loaded so the pointer stops at FEATURE_COUNT-1.
    always_comb begin
        w_state_next   = r_state;
        w_rd_ptr_next  = r_rd_ptr;
        w_more_next    = r_more;
        w_load         = 1'b0;
        w_enter_stream = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (bank_full) begin
                        w_state_next   = STREAM;
                        w_enter_stream = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bank_full) begin
                    w_state_next   = STREAM;
                    w_enter_stream = 1'b1;
                end
            end
            STREAM: begin
                w_load = r_more && (!out_valid || out_ready);
                if (w_load) begin
                    if (is_last_idx(r_rd_ptr)) begin
                        w_more_next = 1'b0;
                    end else begin
                        w_rd_ptr_next = r_rd_ptr + feat_idx_t'(1);
                    end
                end
                if (w_accept && out_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_enter_stream) begin
            w_rd_ptr_next = '0;
            w_more_next   = 1'b1;
        end
    end

    hv_out_reg u_out_reg (
        .clk      (clk),
        .srst     (nrst),
        .i_load   (w_load),
        .i_accept (w_accept),
        .i_hv     (w_rd_hv),
        .i_idx    (r_rd_ptr),
        .i_last   (is_last_idx(r_rd_ptr)),
        .o_valid  (out_valid),
        .o_hv     (out_hv),
        .o_idx    (out_idx),
        .o_last   (out_last)
    );

    assign busy = (r_state == WAIT) || (r_state == STREAM);
    assign done = (r_state == DONE);

`ifdef LVL_STREAM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_stall_cnt <= '0;
        end else if (w_enter_stream) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STREAM) && out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_level_hv_streamer.sv
// Self-checking bench for level_hv_streamer: randomized ready/data against a list-based model.
// Compile with +define+LVL_STREAM_STALL_CNT_EN to also check the stall counter.
module tb_level_hv_streamer;
    import hdc_pkg::*;

    logic      clk = 1'b0;
    logic      nrst;
    logic      start;
    logic      bank_full;
    hv_t       level_hvs [FEATURE_COUNT];
    logic      out_valid;
    logic      out_ready;
    hv_t       out_hv;
    feat_idx_t out_idx;
    logic      out_last;
    logic      busy;
    logic      done;
`ifdef LVL_STREAM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    level_hv_streamer dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .bank_full (bank_full),
        .level_hvs (level_hvs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hv    (out_hv),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef LVL_STREAM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // per-cycle samples: outputs seen after an edge plus the ready driven for the next edge
    logic      smp_valid [$];
    logic      smp_ready [$];
    logic      smp_last  [$];
    logic      smp_done  [$];
    logic      smp_busy  [$];
    feat_idx_t smp_idx   [$];
    hv_t       smp_hv    [$];
    int        rst_j;
    bit        timed_out;

    // accepted beats, derived from the samples
    int        acc_j    [$];
    int        acc_idx  [$];
    hv_t       acc_hv   [$];
    logic      acc_last [$];

    function automatic hv_t exp_hv(input int i, input logic [31:0] seed);
        logic [31:0] w;
        w = 32'(i) ^ seed;
        return {(HV_DIM/32){w}};
    endfunction

    task automatic fill_bank(input logic [31:0] seed);
        for (int i = 0; i < FEATURE_COUNT; i++) level_hvs[i] = exp_hv(i, seed);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall at idx 10 and 3-cycle stall at idx 616
    task automatic run_stream(input int mode, input int bf_rise_at, input bit pulse_starts,
                              input int reset_at_idx, input int max_cycles);
        int   stall_left = 0;
        bit   s10 = 0, s616 = 0, p100 = 0, p300 = 0;
        int   done_j = -1;
        logic rdy;
        smp_valid.delete(); smp_ready.delete(); smp_last.delete(); smp_done.delete();
        smp_busy.delete();  smp_idx.delete();   smp_hv.delete();
        rst_j     = -1;
        timed_out = 1'b1;
        for (int j = 0; j < max_cycles; j++) begin
            tick();
            start = 1'b0;
            nrst  = 1'b0;
            if (j == bf_rise_at) bank_full = 1'b1;
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                if (out_valid && out_idx == 10 && !s10) begin s10 = 1; stall_left = 5; end
                if (out_valid && out_idx == 616 && !s616) begin s616 = 1; stall_left = 3; end
                rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            if (pulse_starts && out_valid && out_idx == 100 && !p100) begin p100 = 1; start = 1'b1; end
            if (pulse_starts && out_valid && out_idx == 300 && !p300) begin p300 = 1; start = 1'b1; end
            if (reset_at_idx >= 0 && rst_j < 0 && out_valid && out_idx == feat_idx_t'(reset_at_idx)) begin
                nrst  = 1'b1;
                rst_j = j;
            end
            smp_valid.push_back(out_valid); smp_ready.push_back(rdy); smp_last.push_back(out_last);
            smp_done.push_back(done);       smp_busy.push_back(busy); smp_idx.push_back(out_idx);
            smp_hv.push_back(out_hv);
            out_ready = rdy;
            if (done && done_j < 0) done_j = j;
            if ((done_j >= 0 && j >= done_j + 2) || (rst_j >= 0 && j >= rst_j + 2)) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        nrst  = 1'b0;
    endtask

    task automatic extract_beats;
        acc_j.delete(); acc_idx.delete(); acc_hv.delete(); acc_last.delete();
        foreach (smp_valid[j]) begin
            if (smp_valid[j] && smp_ready[j]) begin
                acc_j.push_back(j);
                acc_idx.push_back(int'(smp_idx[j]));
                acc_hv.push_back(smp_hv[j]);
                acc_last.push_back(smp_last[j]);
            end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b1; start = 1'b0; bank_full = 1'b0; out_ready = 1'b0;
        fill_bank(32'h0);
        tick(); tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (out_idx !== '0) $display("FAIL reset_idx got=%0d want=0", out_idx); else n_pass++;
        n_checks++; if (out_hv !== '0) $display("FAIL reset_hv got=%h want=0", out_hv[31:0]); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last got=%b want=0", out_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        nrst = 1'b0;
        tick();
    endtask

    task automatic test_full_rate;
        int fv = -1, nd = 0, dj = -1, nbusy_low = 0, want_dj;
        logic busy_at_done;
        fill_bank(32'h0);
        bank_full = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b1;
        run_stream(0, -1, 0, -1, 2000);
        extract_beats();
        foreach (smp_valid[j]) if (smp_valid[j] && fv < 0) fv = j;
        foreach (smp_done[j]) if (smp_done[j]) begin nd++; dj = j; end
        for (int j = 0; j < dj; j++) if (!smp_busy[j]) nbusy_low++;
        n_checks++; if (timed_out !== 1'b0) $display("FAIL full_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (fv != 1) $display("FAIL full_first_valid_cycle got=%0d want=1", fv); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL full_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k) $display("FAIL full_idx beat=%0d got=%0d want=%0d", k, acc_idx[k], k); else n_pass++;
            n_checks++; if (acc_hv[k] !== exp_hv(k, 32'h0)) $display("FAIL full_hv beat=%0d got=%h want=%h", k, acc_hv[k][31:0], k); else n_pass++;
            n_checks++; if (acc_last[k] !== (k == FEATURE_COUNT-1)) $display("FAIL full_last beat=%0d got=%b want=%b", k, acc_last[k], k == FEATURE_COUNT-1); else n_pass++;
            n_checks++; if (acc_j[k] != k + 1) $display("FAIL full_throughput beat=%0d got_cycle=%0d want_cycle=%0d", k, acc_j[k], k + 1); else n_pass++;
        end
        want_dj = (acc_j.size() > 0) ? acc_j[acc_j.size()-1] + 1 : -2;
        busy_at_done = (dj >= 0) ? smp_busy[dj] : 1'bx;
        n_checks++; if (nd != 1) $display("FAIL full_done_count got=%0d want=1", nd); else n_pass++;
        n_checks++; if (dj != want_dj) $display("FAIL full_done_cycle got=%0d want=%0d", dj, want_dj); else n_pass++;
        n_checks++; if (busy_at_done !== 1'b0) $display("FAIL full_busy_in_done got=%b want=0", busy_at_done); else n_pass++;
        n_checks++; if (nbusy_low != 0) $display("FAIL full_busy_during_stream low_cycles=%0d want=0", nbusy_low); else n_pass++;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL full_idle_after got=%b%b want=00", busy, out_valid); else n_pass++;
    endtask

    task automatic test_wait;
        int fv = -1, nd = 0, bad_wait = 0;
        logic [31:0] seed = 32'h5A5A0000;
        fill_bank(seed);
        bank_full = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b1;
        run_stream(0, 20, 0, -1, 2000);
        extract_beats();
        foreach (smp_valid[j]) if (smp_valid[j] && fv < 0) fv = j;
        foreach (smp_done[j]) if (smp_done[j]) nd++;
        for (int j = 0; j <= 21 && j < smp_valid.size(); j++) if (smp_valid[j] || !smp_busy[j]) bad_wait++;
        n_checks++; if (timed_out !== 1'b0) $display("FAIL wait_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (bad_wait != 0) $display("FAIL wait_busy_novalid bad_cycles=%0d want=0", bad_wait); else n_pass++;
        n_checks++; if (fv != 22) $display("FAIL wait_first_valid_cycle got=%0d want=22", fv); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL wait_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k || acc_hv[k] !== exp_hv(k, seed) || acc_last[k] !== (k == FEATURE_COUNT-1))
                $display("FAIL wait_beat beat=%0d got_idx=%0d got_hv=%h got_last=%b want_idx=%0d", k, acc_idx[k], acc_hv[k][31:0], acc_last[k], k);
            else n_pass++;
        end
        n_checks++; if (nd != 1) $display("FAIL wait_done_count got=%0d want=1", nd); else n_pass++;
    endtask

    task automatic test_random_ready;
        int nd = 0, nstall = 0;
        logic [31:0] seed = $urandom();
        fill_bank(seed);
        bank_full = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b1;
        run_stream(1, -1, 0, -1, 5000);
        extract_beats();
        foreach (smp_done[j]) if (smp_done[j]) nd++;
        for (int j = 0; j + 1 < smp_valid.size(); j++) begin
            if (smp_valid[j] && !smp_ready[j]) begin
                nstall++;
                n_checks++; if ({smp_valid[j+1], smp_idx[j+1], smp_last[j+1]} !== {1'b1, smp_idx[j], smp_last[j]})
                    $display("FAIL rand_stall_side cycle=%0d got=%b/%0d/%b want=1/%0d/%b", j+1, smp_valid[j+1], smp_idx[j+1], smp_last[j+1], smp_idx[j], smp_last[j]);
                else n_pass++;
                n_checks++; if (smp_hv[j+1] !== smp_hv[j]) $display("FAIL rand_stall_hv cycle=%0d got=%h want=%h", j+1, smp_hv[j+1][31:0], smp_hv[j][31:0]); else n_pass++;
            end
        end
        n_checks++; if (timed_out !== 1'b0) $display("FAIL rand_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (nstall == 0) $display("FAIL rand_no_stalls got=%0d want>0", nstall); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL rand_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k || acc_hv[k] !== exp_hv(k, seed) || acc_last[k] !== (k == FEATURE_COUNT-1))
                $display("FAIL rand_beat beat=%0d got_idx=%0d got_hv=%h got_last=%b want_idx=%0d", k, acc_idx[k], acc_hv[k][31:0], acc_last[k], k);
            else n_pass++;
        end
        n_checks++; if (nd != 1) $display("FAIL rand_done_count got=%0d want=1", nd); else n_pass++;
    endtask

    task automatic test_start_ignored;
        int nd = 0;
        logic [31:0] seed = 32'hC0DE0000;
        fill_bank(seed);
        bank_full = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b1;
        run_stream(0, -1, 1, -1, 2000);
        extract_beats();
        foreach (smp_done[j]) if (smp_done[j]) nd++;
        n_checks++; if (timed_out !== 1'b0) $display("FAIL restart_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL restart_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k || acc_hv[k] !== exp_hv(k, seed))
                $display("FAIL restart_beat beat=%0d got_idx=%0d got_hv=%h want_idx=%0d", k, acc_idx[k], acc_hv[k][31:0], k);
            else n_pass++;
        end
        n_checks++; if (nd != 1) $display("FAIL restart_done_count got=%0d want=1", nd); else n_pass++;
        tick(); tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL restart_idle_after got=%b%b want=00", busy, out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int r;
        logic [31:0] seed = 32'h00AB0000;
        fill_bank(seed);
        bank_full = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b1;
        run_stream(0, -1, 0, 200, 2000);
        r = rst_j + 1;
        n_checks++; if (rst_j < 0 || r >= smp_valid.size()) $display("FAIL rstmid_reached got=%0d want>=0", rst_j); else n_pass++;
        if (rst_j >= 0 && r < smp_valid.size()) begin
            n_checks++; if (smp_valid[r] !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", smp_valid[r]); else n_pass++;
            n_checks++; if (smp_idx[r] !== '0) $display("FAIL rstmid_idx got=%0d want=0", smp_idx[r]); else n_pass++;
            n_checks++; if (smp_busy[r] !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", smp_busy[r]); else n_pass++;
            n_checks++; if (smp_hv[r] !== '0 || smp_last[r] !== 1'b0 || smp_done[r] !== 1'b0)
                $display("FAIL rstmid_rest got_hv=%h got_last=%b got_done=%b want=0", smp_hv[r][31:0], smp_last[r], smp_done[r]);
            else n_pass++;
        end
        start = 1'b1;
        run_stream(0, -1, 0, -1, 2000);
        extract_beats();
        n_checks++; if (timed_out !== 1'b0) $display("FAIL rstmid_restream_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL rstmid_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k || acc_hv[k] !== exp_hv(k, seed))
                $display("FAIL rstmid_beat beat=%0d got_idx=%0d got_hv=%h want_idx=%0d", k, acc_idx[k], acc_hv[k][31:0], k);
            else n_pass++;
        end
    endtask

    task automatic test_stall_cnt;
        logic [31:0] seed = 32'h77000000;
        fill_bank(seed);
        bank_full = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b1;
        run_stream(2, -1, 0, -1, 2000);
        extract_beats();
        n_checks++; if (timed_out !== 1'b0) $display("FAIL stall_timeout got=%b want=0", timed_out); else n_pass++;
        n_checks++; if (acc_idx.size() != FEATURE_COUNT) $display("FAIL stall_beat_count got=%0d want=%0d", acc_idx.size(), FEATURE_COUNT); else n_pass++;
        for (int k = 0; k < acc_idx.size(); k++) begin
            n_checks++; if (acc_idx[k] != k || acc_hv[k] !== exp_hv(k, seed) || acc_last[k] !== (k == FEATURE_COUNT-1))
                $display("FAIL stall_beat beat=%0d got_idx=%0d got_hv=%h got_last=%b want_idx=%0d", k, acc_idx[k], acc_hv[k][31:0], acc_last[k], k);
            else n_pass++;
        end
`ifdef LVL_STREAM_STALL_CNT_EN
        n_checks++; if (stall_cnt !== 32'd8) $display("FAIL stall_cnt_after_done got=%0d want=8", stall_cnt); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (stall_cnt !== 32'd0 || busy !== 1'b1) $display("FAIL stall_cnt_cleared got=%0d busy=%b want=0 busy=1", stall_cnt, busy); else n_pass++;
        run_stream(0, -1, 0, -1, 2000);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL stall_drain_timeout got=%b want=0", timed_out); else n_pass++;
`endif
    endtask

    initial begin
        nrst = 1'b1; start = 1'b0; bank_full = 1'b0; out_ready = 1'b0;
        test_reset();
        test_full_rate();
        test_wait();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_stall_cnt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
